// File: rtl/f1_stage_sched_pkg.sv
// Shared configuration for the f1 stage scheduler: LLR geometry, state encoding
// and the helpers that turn len_log2 into a beat count and a lane mask.
package f1_stage_sched_pkg;

  localparam int WIDTH   = 6;
  localparam int P       = 4;
  localparam int ADDR_W  = 8;
  localparam int LEN_W   = 4;
  localparam int LOG2P   = $clog2(P);
  localparam int MAX_LEN = LOG2P + ADDR_W;

  localparam logic [WIDTH-1:0] LLR_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] LLR_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Oversized lengths are clamped so the beat count always fits the address space.
  function automatic int clamp_len(input logic [LEN_W-1:0] len);
    int le;
    le = int'(len);
    if (le > MAX_LEN) le = MAX_LEN;
    return le;
  endfunction

  function automatic logic [ADDR_W-1:0] nb_minus1(input logic [LEN_W-1:0] len);
    int le;
    le = clamp_len(len);
    if (le <= LOG2P) return '0;
    return ADDR_W'((1 << (le - LOG2P)) - 1);
  endfunction

  function automatic logic [P-1:0] lane_mask(input logic [LEN_W-1:0] len);
    int le;
    le = clamp_len(len);
    if (le >= LOG2P) return '1;
    return P'((1 << (1 << le)) - 1);
  endfunction

endpackage

// File: rtl/f1_stage_sched_lanes.sv
// P parallel f1 lanes, d = min(a, sat(b+c)), built from the existing
// saturating_adder and minsum primitives. Purely combinational.
module saturating_adder
  import f1_stage_sched_pkg::*;
(
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic [WIDTH-1:0] o_s
);
  logic [WIDTH:0] w_sum;

  assign w_sum = {i_x[WIDTH-1], i_x} + {i_y[WIDTH-1], i_y};

  // Overflow shows up as disagreement between the two top bits of the extended sum.
  assign o_s = (w_sum[WIDTH] == w_sum[WIDTH-1]) ? w_sum[WIDTH-1:0]
             : (w_sum[WIDTH] ? LLR_MIN : LLR_MAX);
endmodule

module minsum
  import f1_stage_sched_pkg::*;
(
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic [WIDTH-1:0] o_m
);
  assign o_m = ($signed(i_x) < $signed(i_y)) ? i_x : i_y;
endmodule

module f1
  import f1_stage_sched_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_d
);
  logic [WIDTH-1:0] w_s;

  saturating_adder u_add (.i_x(i_b), .i_y(i_c), .o_s(w_s));
  minsum           u_min (.i_x(i_a), .i_y(w_s), .o_m(o_d));
endmodule

module f1_stage_sched_lanes
  import f1_stage_sched_pkg::*;
(
  input  logic [P*WIDTH-1:0] i_a,
  input  logic [P*WIDTH-1:0] i_b,
  input  logic [P*WIDTH-1:0] i_c,
  output logic [P*WIDTH-1:0] o_d
);
  for (genvar k = 0; k < P; k++) begin : g_lane
    f1 u_f1 (
      .i_a(i_a[k*WIDTH +: WIDTH]),
      .i_b(i_b[k*WIDTH +: WIDTH]),
      .i_c(i_c[k*WIDTH +: WIDTH]),
      .o_d(o_d[k*WIDTH +: WIDTH])
    );
  end
endmodule

// File: rtl/f1_stage_sched.sv
// Sequences one f-type LLR update pass through P shared f1 lanes:
// issue reads, compute in the lanes, write back two cycles later.
module f1_stage_sched
  import f1_stage_sched_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [LEN_W-1:0]     i_len_log2,
  input  logic [ADDR_W-1:0]    i_base_a,
  input  logic [ADDR_W-1:0]    i_base_b,
  input  logic [ADDR_W-1:0]    i_base_c,
  input  logic [ADDR_W-1:0]    i_base_d,
  input  logic                 i_stall,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_rd_en,
  output logic [ADDR_W-1:0]    o_rd_addr_a,
  output logic [ADDR_W-1:0]    o_rd_addr_b,
  output logic [ADDR_W-1:0]    o_rd_addr_c,
  input  logic [P*WIDTH-1:0]   i_rd_data_a,
  input  logic [P*WIDTH-1:0]   i_rd_data_b,
  input  logic [P*WIDTH-1:0]   i_rd_data_c,
  output logic                 o_wr_en,
  output logic [ADDR_W-1:0]    o_wr_addr,
  output logic [P*WIDTH-1:0]   o_wr_data,
  output logic [P-1:0]         o_wr_mask
);

  state_e              r_state;
  state_e              w_next;

  logic [ADDR_W-1:0]   r_base_a;
  logic [ADDR_W-1:0]   r_base_b;
  logic [ADDR_W-1:0]   r_base_c;
  logic [ADDR_W-1:0]   r_base_d;
  logic [ADDR_W-1:0]   r_nb_m1;
  logic [P-1:0]        r_mask;
  logic [ADDR_W-1:0]   r_beat;

  logic                r_v1;
  logic [ADDR_W-1:0]   r_waddr1;
  logic [P-1:0]        r_mask1;

  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [P*WIDTH-1:0]  r_wr_data;
  logic [P-1:0]        r_wr_mask;

  logic                w_accept;
  logic                w_issue;
  logic                w_last;
  logic                w_drained;
  logic [P*WIDTH-1:0]  w_lane_d;

  assign w_accept  = (r_state == S_IDLE) && i_start;
  assign w_issue   = (r_state == S_ISSUE) && !i_stall;
  assign w_last    = w_issue && (r_beat == r_nb_m1);
  assign w_drained = !r_v1 && !r_wr_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start)  w_next = S_ISSUE;
      S_ISSUE: if (w_last)   w_next = S_DRAIN;
      S_DRAIN: if (w_drained) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_rd_en = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      S_ISSUE: begin
        o_rd_en = !i_stall;
        o_busy  = 1'b1;
      end
      S_DRAIN: o_busy = 1'b1;
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Pass configuration and beat counter; the counter only moves on an actual issue.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_base_a <= '0;
      r_base_b <= '0;
      r_base_c <= '0;
      r_base_d <= '0;
      r_nb_m1  <= '0;
      r_mask   <= '0;
      r_beat   <= '0;
    end else if (w_accept) begin
      r_base_a <= i_base_a;
      r_base_b <= i_base_b;
      r_base_c <= i_base_c;
      r_base_d <= i_base_d;
      r_nb_m1  <= nb_minus1(i_len_log2);
      r_mask   <= lane_mask(i_len_log2);
      r_beat   <= '0;
    end else if (w_issue) begin
      r_beat   <= r_beat + 1'b1;
    end
  end

  assign o_rd_addr_a = r_base_a + r_beat;
  assign o_rd_addr_b = r_base_b + r_beat;
  assign o_rd_addr_c = r_base_c + r_beat;

  f1_stage_sched_lanes u_lanes (
    .i_a(i_rd_data_a),
    .i_b(i_rd_data_b),
    .i_c(i_rd_data_c),
    .o_d(w_lane_d)
  );

  // Two-stage shift: stage 1 tracks the beat whose data is arriving, stage 2 is the write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1      <= 1'b0;
      r_waddr1  <= '0;
      r_mask1   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_mask <= '0;
    end else begin
      r_v1 <= w_issue;
      if (w_issue) begin
        r_waddr1 <= r_base_d + r_beat;
        r_mask1  <= r_mask;
      end
      r_wr_en   <= r_v1;
      r_wr_mask <= r_v1 ? r_mask1 : '0;
      if (r_v1) begin
        r_wr_addr <= r_waddr1;
        r_wr_data <= w_lane_d;
      end
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_wr_mask = r_wr_mask;

endmodule

// File: tb/tb_f1_stage_sched.sv
// Self-checking bench for f1_stage_sched: a memory model answers reads, and a
// pass-level reference predicts every strobe, address and write beat per cycle.
module tb_f1_stage_sched;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1, i_start = 1'b0, i_stall = 1'b0;
  logic [3:0]  i_len_log2 = '0;
  logic [7:0]  i_base_a = '0, i_base_b = '0, i_base_c = '0, i_base_d = '0;
  logic [23:0] i_rd_data_a = '0, i_rd_data_b = '0, i_rd_data_c = '0;
  logic        o_busy, o_done, o_rd_en, o_wr_en;
  logic [7:0]  o_rd_addr_a, o_rd_addr_b, o_rd_addr_c, o_wr_addr;
  logic [23:0] o_wr_data;
  logic [3:0]  o_wr_mask;

  always #5 clk = ~clk;

  f1_stage_sched dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_len_log2(i_len_log2),
    .i_base_a(i_base_a), .i_base_b(i_base_b), .i_base_c(i_base_c), .i_base_d(i_base_d),
    .i_stall(i_stall), .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en),
    .o_rd_addr_a(o_rd_addr_a), .o_rd_addr_b(o_rd_addr_b), .o_rd_addr_c(o_rd_addr_c),
    .i_rd_data_a(i_rd_data_a), .i_rd_data_b(i_rd_data_b), .i_rd_data_c(i_rd_data_c),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_mask(o_wr_mask)
  );

  logic [23:0] mem_a [256];
  logic [23:0] mem_b [256];
  logic [23:0] mem_c [256];

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [23:0] data;
    logic [3:0]  mask;
  } wr_t;
  wr_t wq[$];

  int n_checks = 0, n_err = 0, cyc = 0, t_start = 0;

  // reference pass state
  bit         m_pass = 0;
  int         m_start = 0, m_done = -1, m_beats = 0, m_nb = 0;
  logic [7:0] m_ba, m_bb, m_bc, m_bd;
  logic [3:0] m_mask;

  // observations of the DUT for the hand-computed checks
  int          obs_done = -1, obs_wr_cnt = 0;
  logic [23:0] obs_wd;
  logic [7:0]  obs_wa;
  logic [3:0]  obs_wm;
  logic [7:0]  obs_ra[$];

  bit         pend_rd = 0;
  logic [7:0] pend_a, pend_b, pend_c;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [5:0] f1m(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    int s, ai;
    s  = int'($signed(b)) + int'($signed(c));
    if (s > 31)  s = 31;
    if (s < -32) s = -32;
    ai = int'($signed(a));
    return 6'((ai < s) ? ai : s);
  endfunction

  function automatic logic [23:0] lanes_d(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    logic [23:0] d;
    for (int k = 0; k < 4; k++) d[k*6 +: 6] = f1m(a[k*6 +: 6], b[k*6 +: 6], c[k*6 +: 6]);
    return d;
  endfunction

  task automatic run_cycle(input bit st, input bit stl, input bit rs);
    bit         was_idle, exp_wr, exp_rd, exp_busy, exp_done;
    logic [7:0] off;
    int         le, lanes;
    wr_t        w;
    @(posedge clk);
    #1;
    cyc++;
    i_rst = rs; i_start = st; i_stall = stl;
    if (pend_rd) begin
      i_rd_data_a = mem_a[pend_a]; i_rd_data_b = mem_b[pend_b]; i_rd_data_c = mem_c[pend_c];
    end else begin
      i_rd_data_a = 24'($urandom); i_rd_data_b = 24'($urandom); i_rd_data_c = 24'($urandom);
    end
    #1;
    was_idle = !m_pass;

    exp_wr = (wq.size() > 0) && (wq[0].cyc == cyc);
    chk("wr_en", 32'(o_wr_en), 32'(exp_wr));
    if (exp_wr) begin
      chk("wr_addr", 32'(o_wr_addr), 32'(wq[0].addr));
      chk("wr_data", 32'(o_wr_data), 32'(wq[0].data));
      chk("wr_mask", 32'(o_wr_mask), 32'(wq[0].mask));
      void'(wq.pop_front());
    end
    if (o_wr_en) begin
      obs_wr_cnt++;
      if (obs_wr_cnt == 1) begin obs_wd = o_wr_data; obs_wa = o_wr_addr; obs_wm = o_wr_mask; end
    end

    exp_busy = m_pass && (cyc > m_start) && (m_done < 0 || cyc < m_done);
    exp_done = m_pass && (cyc == m_done);
    exp_rd   = m_pass && (cyc > m_start) && (m_beats < m_nb) && !stl;
    chk("busy", 32'(o_busy), 32'(exp_busy));
    chk("done", 32'(o_done), 32'(exp_done));
    chk("rd_en", 32'(o_rd_en), 32'(exp_rd));
    if (o_done) obs_done = cyc;
    if (o_rd_en) obs_ra.push_back(o_rd_addr_a);

    if (exp_rd) begin
      off = 8'(m_beats);
      chk("rd_addr_a", 32'(o_rd_addr_a), 32'(8'(m_ba + off)));
      chk("rd_addr_b", 32'(o_rd_addr_b), 32'(8'(m_bb + off)));
      chk("rd_addr_c", 32'(o_rd_addr_c), 32'(8'(m_bc + off)));
      w.cyc  = cyc + 2;
      w.addr = m_bd + off;
      w.data = lanes_d(mem_a[8'(m_ba + off)], mem_b[8'(m_bb + off)], mem_c[8'(m_bc + off)]);
      w.mask = m_mask;
      wq.push_back(w);
      m_beats++;
      if (m_beats == m_nb) m_done = cyc + 4;
    end

    pend_rd = o_rd_en; pend_a = o_rd_addr_a; pend_b = o_rd_addr_b; pend_c = o_rd_addr_c;
    if (exp_done) m_pass = 0;

    if (rs) begin
      m_pass = 0; wq.delete(); pend_rd = 0;
    end else if (st && was_idle) begin
      le = (int'(i_len_log2) > 10) ? 10 : int'(i_len_log2);
      lanes   = 1 << le;
      m_nb    = (lanes >= 4) ? lanes / 4 : 1;
      m_mask  = (lanes >= 4) ? 4'hF : 4'((1 << lanes) - 1);
      m_pass  = 1; m_start = cyc; m_done = -1; m_beats = 0;
      m_ba = i_base_a; m_bb = i_base_b; m_bc = i_base_c; m_bd = i_base_d;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, 32'(o_busy), 32'd0);
    chk({nm, "_done"}, 32'(o_done), 32'd0);
    chk({nm, "_rd_en"}, 32'(o_rd_en), 32'd0);
    chk({nm, "_rd_addr"}, 32'({o_rd_addr_a, o_rd_addr_b, o_rd_addr_c}), 32'd0);
    chk({nm, "_wr_en"}, 32'(o_wr_en), 32'd0);
    chk({nm, "_wr_addr"}, 32'(o_wr_addr), 32'd0);
    chk({nm, "_wr_data"}, 32'(o_wr_data), 32'd0);
    chk({nm, "_wr_mask"}, 32'(o_wr_mask), 32'd0);
  endtask

  task automatic begin_pass(input logic [3:0] len, input logic [7:0] ba, input logic [7:0] bb,
                            input logic [7:0] bc, input logic [7:0] bd);
    i_len_log2 = len; i_base_a = ba; i_base_b = bb; i_base_c = bc; i_base_d = bd;
    obs_wr_cnt = 0; obs_done = -1; obs_ra.delete();
    run_cycle(1'b1, 1'b0, 1'b0);
    t_start = cyc;
  endtask

  // mode 0: no stall, 1: random stall and stray starts, 2: stall 3..5 cycles after start
  task automatic wait_done(input int budget, input int mode);
    bit stl, st;
    int rel;
    for (int i = 0; i < budget && obs_done < 0; i++) begin
      rel = cyc + 1 - t_start;
      stl = (mode == 1) ? ($urandom_range(0, 3) == 0) : ((mode == 2) && rel >= 3 && rel <= 5);
      st  = (mode == 1) && ($urandom_range(0, 15) == 0);
      run_cycle(st, stl, 1'b0);
    end
    if (obs_done < 0) begin
      n_checks++; n_err++;
      $display("FAIL done_timeout: got no done within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 24'($urandom); mem_b[i] = 24'($urandom); mem_c[i] = 24'($urandom);
    end
    // lanes (0..3): a={5,7,31,0} b={3,-2,31,-32} c={4,1,31,-1} -> d={5,-1,31,-32}
    mem_a[8'h10] = {6'd0, 6'd31, 6'd7, 6'd5};
    mem_b[8'h20] = {6'h20, 6'd31, 6'h3E, 6'd3};
    mem_c[8'h30] = {6'h3F, 6'd31, 6'd1, 6'd4};

    run_cycle(0, 0, 1);
    run_cycle(0, 1, 1);
    run_cycle(0, 0, 0);
    chk_zero("reset");

    begin_pass(4'd4, 8'h10, 8'h20, 8'h30, 8'h40);
    wait_done(40, 0);
    chk("len4_latency", 32'(obs_done - t_start), 32'd8);
    chk("len4_first_data", 32'(obs_wd), 32'h0081_FFC5);
    chk("len4_first_addr", 32'(obs_wa), 32'h40);
    chk("len4_mask", 32'(obs_wm), 32'hF);
    chk("len4_writes", 32'(obs_wr_cnt), 32'd4);

    begin_pass(4'd1, 8'h50, 8'h60, 8'h70, 8'h80);
    wait_done(40, 0);
    chk("len1_latency", 32'(obs_done - t_start), 32'd5);
    chk("len1_mask", 32'(obs_wm), 32'h3);
    chk("len1_writes", 32'(obs_wr_cnt), 32'd1);

    begin_pass(4'd4, 8'h05, 8'h15, 8'h25, 8'h35);
    wait_done(40, 2);
    chk("stall_latency", 32'(obs_done - t_start), 32'd11);
    chk("stall_writes", 32'(obs_wr_cnt), 32'd4);

    begin_pass(4'd4, 8'hFE, 8'h11, 8'h22, 8'h33);
    wait_done(40, 0);
    chk("wrap_reads", 32'(obs_ra.size()), 32'd4);
    if (obs_ra.size() == 4)
      chk("wrap_rd_addr_a", {obs_ra[0], obs_ra[1], obs_ra[2], obs_ra[3]}, 32'hFEFF_0001);

    begin_pass(4'd5, 8'h40, 8'h50, 8'h60, 8'h70);
    run_cycle(0, 0, 0);
    run_cycle(0, 0, 1);
    run_cycle(0, 0, 0);
    chk_zero("midrst");
    obs_wr_cnt = 0; obs_done = -1;
    repeat (12) run_cycle(0, 0, 0);
    chk("midrst_writes", 32'(obs_wr_cnt), 32'd0);
    chk("midrst_no_done", 32'(obs_done), 32'hFFFF_FFFF);

    begin_pass(4'd4, 8'h80, 8'h90, 8'hA0, 8'hB0);
    run_cycle(0, 0, 0);
    i_len_log2 = 4'd6; i_base_a = 8'h01; i_base_b = 8'h02; i_base_c = 8'h03; i_base_d = 8'h04;
    run_cycle(1, 0, 0);
    wait_done(40, 0);
    chk("busy_start_latency", 32'(obs_done - t_start), 32'd8);
    chk("busy_start_writes", 32'(obs_wr_cnt), 32'd4);
    chk("busy_start_addr", 32'(obs_wa), 32'hB0);

    begin_pass(4'd2, 8'h12, 8'h34, 8'h56, 8'h78);
    repeat (4) run_cycle(0, 0, 0);
    run_cycle(1, 0, 0);
    chk("done_cycle_seen", 32'(obs_done - t_start), 32'd5);
    repeat (6) run_cycle(0, 0, 0);
    chk("done_start_ignored", 32'(obs_ra.size()), 32'd1);

    for (int p = 0; p < 40; p++) begin
      repeat ($urandom_range(0, 3)) run_cycle(0, 1'($urandom_range(0, 1)), 0);
      begin_pass(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6)),
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      wait_done(2000, 1);
    end
    repeat (3) run_cycle(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
